// File: rtl/ser_lane_arbiter.sv
// Round-robin arbiter that shares one serial lane between N parallel-word requesters.
// Each granted word is shifted out MSB-first, followed by GAP idle cycles and a done pulse.
module ser_lane_arbiter #(
    parameter int N   = 4,
    parameter int W   = 8,
    parameter int GAP = 1,
    localparam int IDW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic [N-1:0]     req_valid,
    input  logic [N*W-1:0]   req_data,
    output logic [N-1:0]     req_ready,
    output logic             ser_dout,
    output logic             ser_dout_valid,
    output logic             ser_first,
    output logic             busy,
    output logic             done_valid,
    output logic [IDW-1:0]   done_id
);

    localparam int CW = $clog2(W);
    localparam logic [3:0] GAP_LD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   shreg;
    logic [CW-1:0]  bit_cnt;
    logic [3:0]     gap_cnt;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] cur_id;
    logic [IDW-1:0] gnt_id;
    logic           gnt_found;
    logic           grant;
    logic           last_bit;
    int             idx;

    // Search upward from rr_ptr, wrapping modulo N.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = IDW'(idx);
            end
        end
    end

    assign last_bit = (bit_cnt == CW'(W - 1));
    assign grant    = (state == ST_IDLE) && enable && gnt_found;

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        case (state)
            ST_IDLE: begin
                if (grant) begin
                    req_ready[gnt_id] = 1'b1;
                    state_nxt         = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    state_nxt = (GAP > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt == 4'd0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            rr_ptr     <= '0;
            cur_id     <= '0;
            done_valid <= 1'b0;
            done_id    <= '0;
        end else begin
            done_valid <= 1'b0;
            if (grant) begin
                shreg   <= req_data[gnt_id*W +: W];
                cur_id  <= gnt_id;
                rr_ptr  <= (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;
                bit_cnt <= '0;
            end
            if (state == ST_SHIFT) begin
                shreg   <= shreg << 1;
                bit_cnt <= bit_cnt + 1'b1;
                if (last_bit) begin
                    done_valid <= 1'b1;
                    done_id    <= cur_id;
                    gap_cnt    <= GAP_LD;
                end
            end
            if ((state == ST_GAP) && (gap_cnt != 4'd0)) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

    assign ser_dout_valid = (state == ST_SHIFT);
    assign ser_dout       = ser_dout_valid & shreg[W-1];
    assign ser_first      = ser_dout_valid & (bit_cnt == '0);
    assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_ser_lane_arbiter.sv
// Scoreboard bench for ser_lane_arbiter: expected grants, words and done IDs are queued
// as stimulus is applied and retired by a monitor that deserializes the lane.
module tb_ser_lane_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        ser_dout, ser_dout_valid, ser_first, busy, done_valid;
    logic [1:0]  done_id;

    logic        enable_g0;
    logic [3:0]  req_valid_g0;
    logic [31:0] req_data_g0;
    logic [3:0]  req_ready_g0;
    logic        ser_dout_g0, ser_dout_valid_g0, ser_first_g0, busy_g0, done_valid_g0;
    logic [1:0]  done_id_g0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int         exp_grant[$];
    logic [7:0] exp_word[$];
    int         exp_done[$];
    int         first_q[$];

    logic [7:0] mon_sh;
    int         mon_n;

    ser_lane_arbiter #(.N(4), .W(8), .GAP(1)) u0 (
        .clk(clk), .rstn(rstn), .enable(enable), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .ser_dout(ser_dout), .ser_dout_valid(ser_dout_valid),
        .ser_first(ser_first), .busy(busy), .done_valid(done_valid), .done_id(done_id)
    );

    ser_lane_arbiter #(.N(4), .W(8), .GAP(0)) u1 (
        .clk(clk), .rstn(rstn), .enable(enable_g0), .req_valid(req_valid_g0),
        .req_data(req_data_g0), .req_ready(req_ready_g0), .ser_dout(ser_dout_g0),
        .ser_dout_valid(ser_dout_valid_g0), .ser_first(ser_first_g0), .busy(busy_g0),
        .done_valid(done_valid_g0), .done_id(done_id_g0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: acts as the downstream deserializer and retires scoreboard entries.
    always @(negedge clk) begin
        if (!rstn) begin
            mon_n  = 0;
            mon_sh = '0;
        end else begin
            if (req_ready != 4'b0000) begin
                checks++;
                if (exp_grant.size() == 0) begin
                    errors++;
                    $display("FAIL grant_unexpected: req_ready=%b required 0000", req_ready);
                end else begin
                    int g;
                    g = exp_grant.pop_front();
                    if (req_ready !== (4'b0001 << g)) begin
                        errors++;
                        $display("FAIL grant_order: req_ready=%b required %b", req_ready, 4'b0001 << g);
                    end
                end
            end
            checks++;
            if (ser_dout_valid) begin
                if (ser_first !== (mon_n == 0)) begin
                    errors++;
                    $display("FAIL ser_first: got %b required %b at bit %0d", ser_first, (mon_n == 0), mon_n);
                end
                if (mon_n == 0) first_q.push_back(cyc);
                mon_sh = {mon_sh[6:0], ser_dout};
                mon_n++;
                if (mon_n == 8) begin
                    mon_n = 0;
                    checks++;
                    if (exp_word.size() == 0) begin
                        errors++;
                        $display("FAIL word_unexpected: got %h", mon_sh);
                    end else begin
                        logic [7:0] w;
                        w = exp_word.pop_front();
                        if (mon_sh !== w) begin
                            errors++;
                            $display("FAIL deser_word: got %h required %h", mon_sh, w);
                        end
                    end
                end
            end else if (ser_dout !== 1'b0 || ser_first !== 1'b0) begin
                errors++;
                $display("FAIL idle_lane: ser_dout=%b ser_first=%b required 0", ser_dout, ser_first);
            end
            if (done_valid) begin
                checks++;
                if (exp_done.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: done_id=%0d", done_id);
                end else begin
                    int d;
                    d = exp_done.pop_front();
                    if (done_id !== 2'(d)) begin
                        errors++;
                        $display("FAIL done_id: got %0d required %0d", done_id, d);
                    end
                end
            end
        end
    end

    task automatic push_word(input int id, input logic [7:0] w);
        exp_grant.push_back(id);
        exp_word.push_back(w);
        exp_done.push_back(id);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_grant.size() != 0 || exp_word.size() != 0 || exp_done.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: pending grant=%0d word=%0d done=%0d required 0 0 0",
                     name, exp_grant.size(), exp_word.size(), exp_done.size());
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ser_dout, ser_dout_valid, ser_first, busy, done_valid, done_id, req_ready} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0",
                     {ser_dout, ser_dout_valid, ser_first, busy, done_valid, done_id, req_ready});
        end
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, ser_dout_valid, req_ready} !== 6'd0) begin
            errors++;
            $display("FAIL post_reset_idle: got %b required 0", {busy, ser_dout_valid, req_ready});
        end
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        req_data[23:16] = 8'hA5;
        push_word(2, 8'hA5);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready: got %b required 0100", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 4'b0000;
        checks++;
        if ({ser_dout_valid, ser_first, ser_dout, busy, req_ready} !== 8'b1111_0000) begin
            errors++;
            $display("FAIL single_first_bit: got %b required 11110000",
                     {ser_dout_valid, ser_first, ser_dout, busy, req_ready});
        end
        repeat (8) @(posedge clk); #1;
        checks++;
        if ({done_valid, done_id, ser_dout_valid, busy} !== 5'b1_10_0_1) begin
            errors++;
            $display("FAIL single_done: got %b required 11001", {done_valid, done_id, ser_dout_valid, busy});
        end
        @(posedge clk); #1;
        checks++;
        if ({busy, done_valid} !== 2'b00) begin
            errors++;
            $display("FAIL single_back_idle: got %b required 00", {busy, done_valid});
        end
        check_drained("single");
    endtask

    task automatic test_round_robin();
        @(posedge clk); #1;
        req_data = 32'h13121110;
        first_q.delete();
        push_word(0, 8'h10);
        push_word(1, 8'h11);
        push_word(2, 8'h12);
        push_word(3, 8'h13);
        push_word(0, 8'h10);
        req_valid = 4'b1111;
        repeat (41) @(posedge clk); #1;
        req_valid = 4'b0000;
        repeat (12) @(posedge clk); #1;
        checks++;
        if (first_q.size() != 5) begin
            errors++;
            $display("FAIL rr_word_count: got %0d required 5", first_q.size());
        end else begin
            for (int i = 1; i < 5; i++) begin
                checks++;
                if (first_q[i] - first_q[i-1] != 10) begin
                    errors++;
                    $display("FAIL rr_spacing: got %0d required 10", first_q[i] - first_q[i-1]);
                end
            end
        end
        check_drained("round_robin");
    endtask

    task automatic test_pointer_skip();
        @(posedge clk); #1;
        req_data = 32'h44332211;
        push_word(1, 8'h22);
        req_valid = 4'b0010;
        @(posedge clk); #1;
        push_word(0, 8'h11);
        push_word(1, 8'h22);
        req_valid = 4'b0011;
        repeat (20) @(posedge clk); #1;
        req_valid = 4'b0000;
        repeat (12) @(posedge clk); #1;
        check_drained("pointer_skip");
    endtask

    task automatic test_enable_gating();
        @(posedge clk); #1;
        req_data = 32'hC3B2A190;
        push_word(3, 8'hC3);
        req_valid = 4'b1000;
        @(posedge clk); #1;
        req_valid = 4'b1111;
        repeat (3) @(posedge clk); #1;
        enable = 1'b0;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL enable_low_ready: got %b required 0000", req_ready);
            end
        end
        @(posedge clk); #1;
        check_drained("enable_word");
        push_word(0, 8'h90);
        enable = 1'b1;
        @(posedge clk); #1;
        req_valid = 4'b0000;
        repeat (12) @(posedge clk); #1;
        check_drained("enable_resume");
    endtask

    task automatic test_reset_mid_word();
        @(posedge clk); #1;
        req_data = 32'h5D4C3B2A;
        exp_grant.push_back(2);
        req_valid = 4'b0100;
        @(posedge clk); #1;
        req_valid = 4'b0000;
        repeat (5) @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({ser_dout_valid, busy, req_ready, done_valid} !== 7'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %b required 0", {ser_dout_valid, busy, req_ready, done_valid});
        end
        repeat (2) @(posedge clk); #1;
        rstn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (done_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_no_done: got %b required 0", done_valid);
            end
        end
        @(posedge clk); #1;
        push_word(1, 8'h3B);
        push_word(3, 8'h5D);
        req_valid = 4'b1010;
        repeat (11) @(posedge clk); #1;
        req_valid = 4'b0000;
        repeat (12) @(posedge clk); #1;
        check_drained("reset_mid");
    endtask

    task automatic test_gap_zero();
        logic [7:0] w0, w1;
        logic       eb, ev;
        w0 = 8'h81;
        w1 = 8'h6E;
        @(posedge clk); #1;
        req_data_g0 = {16'h0000, w1, w0};
        req_valid_g0 = 4'b0011;
        for (int k = 0; k < 18; k++) begin
            @(posedge clk);
            if (k == 9) begin
                #1 req_valid_g0 = 4'b0000;
            end
            @(negedge clk);
            ev = (k != 8) && (k != 17);
            eb = 1'b0;
            if (k < 8) eb = w0[7-k];
            else if (k > 8 && k < 17) eb = w1[16-k];
            checks++;
            if ({ser_dout_valid_g0, busy_g0, ser_dout_g0} !== {ev, ev, eb}) begin
                errors++;
                $display("FAIL gap0_lane k=%0d: got %b required %b", k,
                         {ser_dout_valid_g0, busy_g0, ser_dout_g0}, {ev, ev, eb});
            end
            if (k == 8 || k == 17) begin
                checks++;
                if ({done_valid_g0, done_id_g0} !== {1'b1, (k == 8) ? 2'd0 : 2'd1}) begin
                    errors++;
                    $display("FAIL gap0_done k=%0d: got %b required %b", k,
                             {done_valid_g0, done_id_g0}, {1'b1, (k == 8) ? 2'd0 : 2'd1});
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn         = 1'b0;
        enable       = 1'b1;
        req_valid    = '0;
        req_data     = '0;
        enable_g0    = 1'b1;
        req_valid_g0 = '0;
        req_data_g0  = '0;
        test_reset();
        test_single();
        do_reset();
        test_round_robin();
        test_pointer_skip();
        test_enable_gating();
        test_reset_mid_word();
        test_gap_zero();
        check_drained("final");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ser_lane_arbiter.md
Name: ser_lane_arbiter

Overview:
- Shares one serial lane between N parallel-word requesters. The lane feeds the team's W-bit serial-to-parallel deserializer.
- Selects a requester round-robin, captures its word, and shifts it out MSB-first with a per-bit valid qualifier.
- Inserts programmable idle gap cycles between words and reports completion with the source ID.
- Sits between the client request ports and the deserializer input (ser_din / ser_din_valid).

Parameters:
- N, 4, number of requesters; N >= 2.
- W, 8, word width in bits; W >= 2; must match the downstream deserializer width.
- GAP, 1, idle cycles inserted after each word before the next arbitration; 0..15.
- IDW, $clog2(N), requester ID width (derived, not user-set).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  1 = new grants allowed; 0 = finish current word, grant nothing new.
- req_valid  in  N  per-requester word-valid.
- req_data  in  N*W  requester i word at bits [i*W +: W].
- req_ready  out  N  one-hot accept; handshake completes when req_valid[i] & req_ready[i].
- ser_dout  out  1  serial bit, MSB first; 0 when ser_dout_valid = 0.
- ser_dout_valid  out  1  bit qualifier; connects to the deserializer ser_din_valid.
- ser_first  out  1  high with the first (MSB) bit of each word.
- busy  out  1  high in SHIFT or GAP.
- done_valid  out  1  one-cycle pulse after the last bit of a word.
- done_id  out  IDW  ID of the completed word; valid while done_valid = 1.

Behaviour:
- Reset values: all registered outputs 0; state IDLE; rr_ptr = 0; bit counter 0; shift register 0.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - If enable = 1 and req_valid is nonzero, grant the first set req_valid bit searching upward from rr_ptr, wrapping modulo N.
  - req_ready[g] = 1 combinationally in the same cycle; all other ready bits stay 0.
  - On the clock edge: capture req_data[g] into the shift register, latch g as cur_id, set rr_ptr = (g+1) mod N, clear the bit counter, go to SHIFT.
  - req_ready is 0 in every state except IDLE, and always 0 when enable = 0.
- SHIFT (exactly W cycles):
  - ser_dout_valid = 1; ser_dout = shift register MSB.
  - Shift left by one each cycle; increment the bit counter.
  - ser_first = 1 only when the bit counter is 0.
  - After the bit with count W-1, go to GAP if GAP > 0, else to IDLE.
  - A word of value D therefore emerges on a deserializer of width W as D.
- done_valid is registered and pulses in the cycle after the last bit, with done_id = cur_id.
- GAP: GAP cycles with ser_dout_valid = 0, then IDLE.
- Throughput and latency:
  - Every word passes through one IDLE cycle, so word spacing is W + GAP + 1 cycles.
  - The first bit appears the cycle after the handshake.
- Requests are level-based: a requester may hold req_valid across grants and gets one word per grant.
  - Deasserting req_valid before a grant is legal; nothing is captured.
- enable going 0 mid-word does not abort the word; the FSM returns to IDLE and waits.
- Requester i's req_data may change after its handshake; only the captured copy is used.
- Asynchronous reset mid-word:
  - Immediately forces all outputs to 0, state to IDLE, and rr_ptr to 0.
  - The partial word is discarded and no done_valid is issued.
- rr_ptr advances only on a grant, never on idle cycles.

Test Plan:
- Single word (N=4, W=8, GAP=1): only req_valid[2] with req_data[2] = 8'hA5 -> req_ready[2] for 1 cycle; bits 1,0,1,0,0,1,0,1 on 8 consecutive valid cycles; ser_first on the first bit; done_valid with done_id = 2; attached deserializer outputs 8'hA5.
- Round-robin: req_valid = 4'b1111 held with words 8'h10..8'h13 -> grant order 0,1,2,3,0; done_id sequence matches; word starts spaced 10 cycles apart.
- Pointer skip: after a grant to 1, req_valid = 4'b0011 -> next grant is 0, not 1; then 1.
- Enable gating: drop enable during bit 3 of a word -> word completes and done_valid fires; no req_ready while enable = 0; restore enable -> grant resumes from rr_ptr.
- Reset mid-word: assert rstn = 0 at bit 5 -> ser_dout_valid, busy and req_ready go 0 immediately; no done_valid; after release, req_valid = 4'b1000 -> grant to 3 (search starts at 0).
- GAP = 0 build: two back-to-back requesters -> 8 valid bits, 1 IDLE cycle, 8 valid bits; busy low only during the IDLE cycle.
